// File: rtl/rv32i_types.sv
// Shared types for the branch predictor: counter type, queued-update record and
// the saturating counter step.
package rv32i_types;

   localparam int unsigned BRP_IDX_W_MAX = 16;

   typedef logic [1:0] brp_ctr_t;

   typedef struct packed {
      logic [BRP_IDX_W_MAX-1:0] idx;
      logic                     taken;
   } brp_upd_t;

   localparam brp_ctr_t BRP_CTR_INIT = 2'b01;

   typedef enum logic [1:0] {StInit, StIdle, StRd, StWb} brp_state_e;

   function automatic brp_ctr_t brp_ctr_next(input brp_ctr_t ctr, input logic taken);
      brp_ctr_t nxt;
      nxt = ctr;
      if (taken && (ctr != 2'b11)) begin
         nxt = ctr + 2'b01;
      end else if (!taken && (ctr != 2'b00)) begin
         nxt = ctr - 2'b01;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/brp_upd_fifo.sv
// Small FIFO of resolved branches awaiting their PHT read-modify-write.
module brp_upd_fifo
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push_i,
   input  brp_upd_t push_data_i,
   input  logic     pop_i,
   output brp_upd_t head_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   brp_upd_t          mem_q [DEPTH];
   logic [PtrW:0]     wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]     rd_ptr_q, rd_ptr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q[PtrW-1:0]] <= push_data_i;
      end
   end

   // Extra pointer bit distinguishes full from empty.
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, push_i};
      rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, pop_i};
   end

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];

endmodule

// File: rtl/brp_update_arbiter.sv
// Owns the single PHT port: initial sweep, fetch lookups, and queued resolution
// updates retired as read-modify-write in idle port cycles.
module brp_update_arbiter
   import rv32i_types::*;
#(
   parameter int unsigned IDX_W      = 8,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_LIM = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lookup_req,
   input  logic [31:0]      lookup_pc,
   output logic             lookup_grant,
   output logic             lookup_valid,
   output logic             lookup_pred,
   input  logic             res_valid,
   input  logic [31:0]      res_pc,
   input  logic             res_taken,
   input  logic             res_mispredicted,
   output logic             res_ready,
   output logic             tbl_en,
   output logic             tbl_we,
   output logic [IDX_W-1:0] tbl_idx,
   output brp_ctr_t         tbl_wdata,
   input  brp_ctr_t         tbl_rdata,
   output logic             busy_init,
   output logic [31:0]      c_total,
   output logic [31:0]      c_correct
);

   localparam int unsigned StarveW = $clog2(STARVE_LIM + 1);

   brp_state_e         state_q, state_d;
   logic [IDX_W-1:0]   init_idx_q, init_idx_d;
   logic [StarveW-1:0] starve_q, starve_d;
   brp_ctr_t           ctr_q, ctr_d;
   logic               lookup_valid_q;
   logic [31:0]        c_total_q, c_total_d, c_correct_q, c_correct_d;

   logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
   brp_upd_t           push_data, head;
   logic [IDX_W-1:0]   lookup_idx, res_idx, head_idx;
   logic               contend, preempt;
   logic               unused_bits;

   assign lookup_idx = lookup_pc[IDX_W+1:2];
   assign res_idx    = res_pc[IDX_W+1:2];
   assign head_idx   = head.idx[IDX_W-1:0];
   assign push_data  = '{idx: BRP_IDX_W_MAX'(res_idx), taken: res_taken};
   assign unused_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0], res_pc[31:IDX_W+2],
                          res_pc[1:0], head.idx[BRP_IDX_W_MAX-1:IDX_W]};

   assign contend   = !fifo_empty && ((state_q == StIdle) || (state_q == StWb));
   assign preempt   = contend && (starve_q >= StarveW'(STARVE_LIM));
   assign busy_init = (state_q == StInit);
   assign res_ready = !fifo_full && !busy_init;
   assign fifo_push = res_valid && res_ready;

   brp_upd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .push_data_i (push_data),
      .pop_i       (fifo_pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      unique case (state_q)
         StInit: begin
            init_idx_d = init_idx_q + IDX_W'(1);
            if (&init_idx_q) state_d = StIdle;
         end
         StIdle:  if (!lookup_grant && !fifo_empty) state_d = StRd;
         StRd:    state_d = StWb;
         StWb:    if (!lookup_grant) state_d = StIdle;
         default: state_d = StInit;
      endcase
   end

   // Port gated during rst so an abandoned write-back never reaches the table.
   always_comb begin
      lookup_grant = 1'b0;
      tbl_en       = 1'b0;
      tbl_we       = 1'b0;
      tbl_idx      = lookup_idx;
      tbl_wdata    = BRP_CTR_INIT;
      fifo_pop     = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StInit: begin
               tbl_en  = 1'b1;
               tbl_we  = 1'b1;
               tbl_idx = init_idx_q;
            end
            StIdle: begin
               if (lookup_req && !preempt) begin
                  lookup_grant = 1'b1;
                  tbl_en       = 1'b1;
               end else if (!fifo_empty) begin
                  tbl_en  = 1'b1;
                  tbl_idx = head_idx;
               end
            end
            StRd: begin
               lookup_grant = lookup_req;
               tbl_en       = lookup_req;
            end
            StWb: begin
               if (lookup_req && !preempt) begin
                  lookup_grant = 1'b1;
                  tbl_en       = 1'b1;
               end else begin
                  tbl_en    = 1'b1;
                  tbl_we    = 1'b1;
                  tbl_idx   = head_idx;
                  tbl_wdata = brp_ctr_next(ctr_q, head.taken);
                  fifo_pop  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      starve_d    = starve_q;
      ctr_d       = ctr_q;
      c_total_d   = c_total_q;
      c_correct_d = c_correct_q;
      if (fifo_empty || preempt) begin
         starve_d = '0;
      end else if (contend && lookup_grant) begin
         starve_d = starve_q + StarveW'(1);
      end
      if (state_q == StRd) ctr_d = tbl_rdata;
      if (fifo_push) begin
         c_total_d = c_total_q + 32'd1;
         if (!res_mispredicted) c_correct_d = c_correct_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         init_idx_q     <= '0;
         starve_q       <= '0;
         ctr_q          <= '0;
         lookup_valid_q <= 1'b0;
         c_total_q      <= '0;
         c_correct_q    <= '0;
      end else begin
         init_idx_q     <= init_idx_d;
         starve_q       <= starve_d;
         ctr_q          <= ctr_d;
         lookup_valid_q <= lookup_grant;
         c_total_q      <= c_total_d;
         c_correct_q    <= c_correct_d;
      end
   end

   assign lookup_valid = lookup_valid_q;
   assign lookup_pred  = lookup_valid_q & tbl_rdata[1];
   assign c_total      = c_total_q;
   assign c_correct    = c_correct_q;

endmodule

// File: tb/tb_brp_update_arbiter.sv
// Scoreboard bench for brp_update_arbiter with a behavioural PHT model and SRAM.
module tb_brp_update_arbiter;

   localparam int IDX_W = 4;
   localparam int DEPTH = 4;
   localparam int N_ENT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lookup_req = 1'b0;
   logic [31:0] lookup_pc = '0;
   logic        lookup_grant, lookup_valid, lookup_pred;
   logic        res_valid = 1'b0;
   logic [31:0] res_pc = '0;
   logic        res_taken = 1'b0;
   logic        res_mispredicted = 1'b0;
   logic        res_ready;
   logic        tbl_en, tbl_we;
   logic [IDX_W-1:0] tbl_idx;
   logic [1:0]  tbl_wdata, tbl_rdata;
   logic        busy_init;
   logic [31:0] c_total, c_correct;

   brp_update_arbiter #(
      .IDX_W      (IDX_W),
      .DEPTH      (DEPTH),
      .STARVE_LIM (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .lookup_req       (lookup_req),
      .lookup_pc        (lookup_pc),
      .lookup_grant     (lookup_grant),
      .lookup_valid     (lookup_valid),
      .lookup_pred      (lookup_pred),
      .res_valid        (res_valid),
      .res_pc           (res_pc),
      .res_taken        (res_taken),
      .res_mispredicted (res_mispredicted),
      .res_ready        (res_ready),
      .tbl_en           (tbl_en),
      .tbl_we           (tbl_we),
      .tbl_idx          (tbl_idx),
      .tbl_wdata        (tbl_wdata),
      .tbl_rdata        (tbl_rdata),
      .busy_init        (busy_init),
      .c_total          (c_total),
      .c_correct        (c_correct)
   );

   always #5 clk = ~clk;

   // Synchronous-read table SRAM.
   logic [1:0] sram [N_ENT];
   always @(posedge clk) begin
      if (tbl_en) begin
         if (tbl_we) sram[tbl_idx] <= tbl_wdata;
         else        tbl_rdata <= sram[tbl_idx];
      end
   end

   typedef struct {int idx; int wdata;} upd_exp_t;

   int       tests = 0;
   int       fails = 0;
   upd_exp_t upd_q[$];
   bit       pred_q[$];
   int       ref_tbl [N_ENT];   // counters with every accepted update applied
   int       com_tbl [N_ENT];   // counters with only retired updates applied
   int       init_exp = 0;
   int       exp_total = 0;
   int       exp_correct = 0;
   bit       obs_grant, obs_ready, obs_push, obs_en, obs_we;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat_next(input int c, input bit tk);
      if (tk) return (c < 3) ? c + 1 : 3;
      return (c > 0) ? c - 1 : 0;
   endfunction

   // Monitor: pops expectations whenever the DUT presents a result.
   always @(negedge clk) begin
      #2;
      if (lookup_valid) begin
         if (pred_q.size() == 0) check("lookup_valid_unexpected", 1, 0);
         else check("lookup_pred", lookup_pred, pred_q.pop_front());
      end
      if (rst) begin
         check("tbl_en_in_rst", tbl_en, 0);
         upd_q.delete();
         pred_q.delete();
         for (int i = 0; i < N_ENT; i++) com_tbl[i] = 1;
         init_exp = 0;
      end else if (init_exp < N_ENT) begin
         check("init_busy", busy_init, 1);
         check("init_write", {tbl_en, tbl_we}, 2'b11);
         check("init_idx", 32'(tbl_idx), init_exp);
         check("init_wdata", 32'(tbl_wdata), 1);
         init_exp++;
      end else begin
         if (init_exp == N_ENT) begin
            check("busy_init_fall", busy_init, 0);
            init_exp++;
         end
         if (tbl_en && tbl_we) begin
            if (upd_q.size() == 0) begin
               check("write_unexpected", 1, 0);
            end else begin
               upd_exp_t e;
               e = upd_q.pop_front();
               check("upd_idx", 32'(tbl_idx), e.idx);
               check("upd_wdata", 32'(tbl_wdata), e.wdata);
               com_tbl[e.idx] = e.wdata;
            end
         end
      end
   end

   // One cycle: observe handshakes at negedge, record expectations, return after next edge.
   task automatic step();
      @(negedge clk);
      obs_grant = lookup_grant;
      obs_ready = res_ready;
      obs_en    = tbl_en;
      obs_we    = tbl_we;
      obs_push  = res_valid && res_ready && !rst;
      if (!rst) begin
         check("res_ready", res_ready, (init_exp >= N_ENT) && (upd_q.size() < DEPTH));
         if (init_exp < N_ENT) check("grant_in_init", lookup_grant, 0);
      end
      if (obs_push) begin
         int idx, nv;
         idx = int'(res_pc[IDX_W+1:2]);
         nv  = sat_next(ref_tbl[idx], res_taken);
         ref_tbl[idx] = nv;
         upd_q.push_back('{idx, nv});
         exp_total++;
         if (!res_mispredicted) exp_correct++;
      end
      if (lookup_grant) pred_q.push_back(com_tbl[int'(lookup_pc[IDX_W+1:2])] >= 2);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      lookup_req = 1'b0;
      res_valid = 1'b0;
      for (int i = 0; i < N_ENT; i++) ref_tbl[i] = 1;
      exp_total = 0;
      exp_correct = 0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_init();
      for (int i = 0; i < 40 && init_exp < N_ENT; i++) step();
      check("init_done", init_exp >= N_ENT, 1);
   endtask

   task automatic push_res(input logic [31:0] pc, input logic tk, input logic mis);
      res_valid = 1'b1;
      res_pc = pc;
      res_taken = tk;
      res_mispredicted = mis;
      for (int i = 0; i < 200; i++) begin
         step();
         if (obs_push) break;
      end
      check("push_accepted", obs_push, 1);
      res_valid = 1'b0;
   endtask

   task automatic drain();
      lookup_req = 1'b0;
      res_valid = 1'b0;
      for (int i = 0; i < 100 && upd_q.size() != 0; i++) step();
      check("drain_empty", upd_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_push, n_grant, sz;
      bit seen_drop, seen_pre;

      do_reset();
      wait_init();

      // First lookup after init: granted immediately, predicts weakly not-taken.
      lookup_req = 1'b1;
      lookup_pc = 32'h0000_0010;
      step();
      check("lookup_grant_first", obs_grant, 1);
      lookup_req = 1'b0;
      step();

      // Two taken updates to idx 4, then predict taken, then saturate.
      push_res(32'h10, 1'b1, 1'b0);
      push_res(32'h10, 1'b1, 1'b0);
      drain();
      lookup_req = 1'b1;
      lookup_pc = 32'h10;
      step();
      lookup_req = 1'b0;
      step();
      push_res(32'h10, 1'b1, 1'b0);
      drain();
      check("sram_idx4_sat", 32'(sram[4]), 3);

      // Back-to-back pushes while fetch hogs the port.
      lookup_req = 1'b1;
      lookup_pc = 32'h40;
      res_valid = 1'b1;
      res_pc = $urandom;
      res_taken = 1'($urandom_range(0, 1));
      res_mispredicted = 1'b0;
      n_push = 0;
      n_grant = 0;
      seen_drop = 0;
      seen_pre = 0;
      for (int i = 0; i < 80 && !(n_push == 5 && seen_pre); i++) begin
         sz = upd_q.size();
         step();
         if (obs_push) begin
            n_push++;
            if (n_push == 5) res_valid = 1'b0;
            else begin
               res_pc = $urandom;
               res_taken = 1'($urandom_range(0, 1));
            end
         end
         if (!obs_ready && !seen_drop) begin
            seen_drop = 1;
            check("ready_drop_after_pushes", n_push, 4);
         end
         if (!seen_pre && sz != 0) begin
            if (obs_grant) n_grant++;
            else begin
               seen_pre = 1;
               check("starve_grants", n_grant, 8);
            end
         end
      end
      check("starve_preempt_seen", seen_pre, 1);
      check("five_pushed", n_push, 5);
      drain();

      // Reset while an update sits in write-back with another queued.
      push_res(32'h20, 1'b0, 1'b0);
      push_res(32'h24, 1'b1, 1'b0);
      check("rmw_read_issued", {obs_en, obs_we}, 2'b10);
      step();
      check("rd_port_idle", obs_en, 0);
      do_reset();
      check("c_total_after_rst", c_total, 0);
      wait_init();

      // Accuracy counters.
      push_res(32'h30, 1'b1, 1'b0);
      push_res(32'h34, 1'b0, 1'b1);
      push_res(32'h38, 1'b1, 1'b0);
      step();
      check("c_total_3", c_total, 3);
      check("c_correct_2", c_correct, 2);
      drain();

      // Randomized traffic.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         lookup_req = ($urandom_range(0, 3) != 0);
         lookup_pc = $urandom;
         if (!res_valid && $urandom_range(0, 3) == 0) begin
            res_valid = 1'b1;
            res_pc = $urandom;
            res_taken = 1'($urandom_range(0, 1));
            res_mispredicted = 1'($urandom_range(0, 1));
         end
         step();
         if (obs_push) res_valid = 1'b0;
      end
      lookup_req = 1'b0;
      for (int i = 0; i < 100 && res_valid; i++) begin
         step();
         if (obs_push) res_valid = 1'b0;
      end
      check("final_push_accepted", res_valid, 0);
      drain();
      step();
      step();
      check("pred_q_empty", pred_q.size(), 0);
      check("c_total_final", c_total, exp_total);
      check("c_correct_final", c_correct, exp_correct);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
